// File: rtl/prio_encoder_q.sv
// -----------------------------------------------------------------------------
// prio_encoder_q
//
// Registered priority encoder with sticky request queuing and a valid/ready
// output handshake. Requests on req_in are merged into a pending register and
// issued one index per cycle to a downstream consumer, so no request is lost
// while the consumer stalls.
//
// Optional feature: define PRIO_ENC_RR_EN to select rotating (round-robin)
// priority. Without it, the highest set bit always wins and no pointer
// register exists.
//
// Parameters
//   WIDTH      number of request lines (2..64)
//   IDX_W      $clog2(WIDTH), width of the encoded index (not overridable)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of pending requests, output and pointer
//   req_in     request lines; bit i requests index i
//   out_ready  consumer accepts out_idx this cycle
//   out_valid  out_idx holds a granted index (this is also the FSM state bit)
//   out_idx    granted index
//   pending    queued requests, excluding the index currently presented
//
// Handshake: a transfer happens on every rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, out_valid and
// out_idx hold their values. out_valid only drops after a transfer with
// nothing left to issue, on clr, or on reset.
// -----------------------------------------------------------------------------
module prio_encoder_q #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] req_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] pending
);

  // The state register is the out_valid output itself.
  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t state;

  logic [WIDTH-1:0] cand;       // pending | req_in
  logic             cand_any;
  logic [IDX_W-1:0] hi_win;     // highest set bit of cand
  logic [IDX_W-1:0] win;        // selected winner
  logic [WIDTH-1:0] win_oh;     // one-hot of winner
  logic [WIDTH-1:0] cur_oh;     // one-hot of the presented index
  logic             stall;      // presenting, consumer not ready

  assign out_valid = (state == VALID);
  assign stall     = (state == VALID) && !out_ready;

  always_comb begin
    cand     = pending | req_in;
    cand_any = |cand;
  end

  // Highest-index-first search over the real request lines only, so an index
  // >= WIDTH can never be produced for non-power-of-2 widths.
  always_comb begin
    hi_win = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cand[i]) hi_win = IDX_W'(i);
    end
  end

`ifdef PRIO_ENC_RR_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lo_win;
  logic             lo_any;
  logic [IDX_W-1:0] ptr_next;

  // Downward search from rr_ptr with wrap: first look for the highest set bit
  // at or below the pointer; if there is none, the search wraps to the top,
  // which is simply the highest set bit overall.
  always_comb begin
    lo_win = '0;
    lo_any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cand[i] && (IDX_W'(i) <= rr_ptr)) begin
        lo_any = 1'b1;
        lo_win = IDX_W'(i);
      end
    end
    win      = lo_any ? lo_win : hi_win;
    ptr_next = (win == '0) ? IDX_W'(WIDTH - 1) : (win - IDX_W'(1));
  end
`else
  always_comb begin
    win = hi_win;
  end
`endif

  always_comb begin
    win_oh = '0;
    cur_oh = '0;
    for (int i = 0; i < WIDTH; i++) begin
      win_oh[i] = (win == IDX_W'(i));
      cur_oh[i] = (out_idx == IDX_W'(i));
    end
  end

  // Single FSM block. Priorities: reset, clr, stall hold, load next, drain.
  // During a stall the presented bit is masked out of the merge: it is already
  // being served, so holding it on req_in must not queue a second grant. On
  // the accepting edge the mask does not apply, so a re-request of the bit
  // being handed over is kept and granted again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      out_idx <= '0;
      pending <= '0;
`ifdef PRIO_ENC_RR_EN
      rr_ptr  <= IDX_W'(WIDTH - 1);
`endif
    end else if (clr) begin
      state   <= EMPTY;
      out_idx <= '0;
      pending <= '0;
`ifdef PRIO_ENC_RR_EN
      rr_ptr  <= IDX_W'(WIDTH - 1);
`endif
    end else if (stall) begin
      pending <= pending | (req_in & ~cur_oh);
    end else if (cand_any) begin
      state   <= VALID;
      out_idx <= win;
      pending <= cand & ~win_oh;
`ifdef PRIO_ENC_RR_EN
      rr_ptr  <= ptr_next;
`endif
    end else begin
      state   <= EMPTY;
      pending <= '0;
    end
  end

endmodule
